spi_slave_sequencer: RTL and testbench

Controller that shares one SPI slave transfer engine between NREQ byte-level requesters. It round-robin arbitrates pending requests and launches the engine with a one-cycle `tx_dp` pulse and the winner's byte. It then waits for the engine's `slave_done`, captures the received byte and returns it to the owner with a one-cycle `done` strobe. It sits between the transfer engine and the register/DMA front ends.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_rr_arbiter.sv | 26 ++
 rtl/spi_slave_sequencer.sv | 125 ++++++++++++
 tb/tb_spi_slave_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave sequencer: FSM encoding, byte width, default timeout.
package spi_pkg;

   localparam int unsigned SPI_BYTE_W      = 8;
   localparam int unsigned TIMEOUT_CYC_DEF = 1023;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LAUNCH  = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_CAPTURE = 2'd3;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: scans upward from last+1 (mod NREQ), first pending wins.
module spi_rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic [NREQ-1:0]  o_win,
   output logic [IDX_W-1:0] o_win_idx,
   output logic             o_any
);

   always_comb begin
      o_win     = '0;
      o_win_idx = '0;
      o_any     = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!o_any && i_req[(int'(i_last) + k) % NREQ]) begin
            o_any                                 = 1'b1;
            o_win_idx                             = IDX_W'((int'(i_last) + k) % NREQ);
            o_win[(int'(i_last) + k) % NREQ]      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_slave_sequencer.sv
// Shares one SPI slave transfer engine between NREQ byte requesters (round-robin).
// Optional WAIT-state timeout enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_slave_sequencer
   import spi_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [NREQ-1:0]            i_req,
   input  logic [NREQ*SPI_BYTE_W-1:0] i_req_data,
   output logic [NREQ-1:0]            o_gnt,
   output logic [NREQ-1:0]            o_done,
   output logic [SPI_BYTE_W-1:0]      o_rx_data,
   output logic                       o_err,
   output logic                       o_busy,
   output logic [SPI_BYTE_W-1:0]      o_eng_data_in,
   output logic                       o_eng_tx_dp,
   input  logic [SPI_BYTE_W-1:0]      i_eng_data_out,
   input  logic                       i_eng_done
);

   localparam int IDX_W = $clog2(NREQ);

   logic [1:0]            r_state;
   logic [IDX_W-1:0]      r_owner;
   logic [IDX_W-1:0]      r_last;
   logic [NREQ-1:0]       r_done;
   logic [SPI_BYTE_W-1:0] r_rx_data;
   logic                  r_err;
   logic [SPI_BYTE_W-1:0] r_eng_data_in;

   logic [NREQ-1:0]       w_win;
   logic [IDX_W-1:0]      w_win_idx;
   logic                  w_any;
   logic [SPI_BYTE_W-1:0] w_sel_data;
   logic [NREQ-1:0]       w_owner_oh;
   logic                  w_timeout;

   spi_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
      .i_req     (i_req),
      .i_last    (r_last),
      .o_win     (w_win),
      .o_win_idx (w_win_idx),
      .o_any     (w_any)
   );

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_win[i]) w_sel_data = w_sel_data | i_req_data[i*SPI_BYTE_W +: SPI_BYTE_W];
   end

   assign w_owner_oh = NREQ'(1) << r_owner;

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] r_cnt;

   // Fires in the last of TIMEOUT_CYC WAIT cycles; a simultaneous eng_done takes priority.
   assign w_timeout = (r_state == ST_WAIT) && !i_eng_done && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                       r_cnt <= '0;
      else if (r_state == ST_LAUNCH)   r_cnt <= '0;
      else if (r_state == ST_WAIT)     r_cnt <= r_cnt + CNT_W'(1);
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_owner       <= '0;
         r_last        <= IDX_W'(NREQ - 1);
         r_done        <= '0;
         r_rx_data     <= '0;
         r_err         <= 1'b0;
         r_eng_data_in <= '0;
      end else begin
         r_done <= '0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_any) begin
               r_owner       <= w_win_idx;
               r_last        <= w_win_idx;
               r_eng_data_in <= w_sel_data;
               r_state       <= ST_LAUNCH;
            end
            ST_LAUNCH: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (i_eng_done) begin
                  r_state <= ST_CAPTURE;
               end else if (w_timeout) begin
                  r_state   <= ST_IDLE;
                  r_done    <= w_owner_oh;
                  r_err     <= 1'b1;
                  r_rx_data <= '0;
               end
            end
            ST_CAPTURE: begin
               r_rx_data <= i_eng_data_out;
               r_done    <= w_owner_oh;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy        = (r_state != ST_IDLE);
   assign o_gnt         = o_busy ? w_owner_oh : '0;
   assign o_eng_tx_dp   = (r_state == ST_LAUNCH);
   assign o_done        = r_done;
   assign o_rx_data     = r_rx_data;
   assign o_eng_data_in = r_eng_data_in;
`ifdef SPI_SEQ_TIMEOUT_EN
   assign o_err         = r_err;
`else
   assign o_err         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// Scoreboard bench for spi_slave_sequencer with a behavioural SPI engine model.
module tb_spi_slave_sequencer;

   typedef struct {
      logic [3:0] done;
      logic [7:0] rx;
      logic       err;
   } exp_done_t;

   typedef struct {
      logic [3:0] gnt;
      logic [7:0] data;
   } exp_launch_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  gnt, done;
   logic [7:0]  rx_data, eng_data_in;
   logic        err, busy, eng_tx_dp;
   logic [7:0]  eng_data_out = '0;
   logic        eng_done_m = 1'b0;
   logic        stray_done = 1'b0;
   logic        eng_done;

   int vectors = 0;
   int miscompares = 0;

   exp_done_t   done_q[$];
   exp_launch_t launch_q[$];
   logic [7:0]  eng_q[$];
   bit          eng_hang = 1'b0;
   int          eng_lat = 2;

   assign eng_done = eng_done_m | stray_done;

   always #5 clk = ~clk;

   spi_slave_sequencer #(.NREQ(4), .TIMEOUT_CYC(20)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_req          (req),
      .i_req_data     (req_data),
      .o_gnt          (gnt),
      .o_done         (done),
      .o_rx_data      (rx_data),
      .o_err          (err),
      .o_busy         (busy),
      .o_eng_data_in  (eng_data_in),
      .o_eng_tx_dp    (eng_tx_dp),
      .i_eng_data_out (eng_data_out),
      .i_eng_done     (eng_done)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic exp_xfer(input int idx, input logic [7:0] tx, input logic [7:0] rx);
      exp_launch_t l;
      exp_done_t   d;
      l.gnt = 4'(1 << idx); l.data = tx;
      d.done = 4'(1 << idx); d.rx = rx; d.err = 1'b0;
      launch_q.push_back(l);
      done_q.push_back(d);
      eng_q.push_back(rx);
   endtask

   task automatic set_req(input int idx, input logic [7:0] tx);
      req_data[idx*8 +: 8] = tx;
      req[idx] = 1'b1;
   endtask

   task automatic wait_dones(input int n, input bit hold, input string nm);
      int cnt = 0;
      int cyc = 0;
      while (cnt < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (done != 4'b0) begin
            cnt++;
            if (!hold) req = req & ~done;
         end
      end
      if (hold) req = '0;
      chk(nm, cnt, n);
   endtask

   task automatic wait_tx_dp(input string nm);
      int cyc = 0;
      while (!eng_tx_dp && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk(nm, {31'b0, eng_tx_dp}, 1);
   endtask

   // Engine model: after tx_dp waits eng_lat cycles, pulses done, then updates data_out.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && eng_tx_dp && !eng_hang) begin
            logic [7:0] r;
            r = (eng_q.size() != 0) ? eng_q.pop_front() : 8'hEE;
            for (int i = 0; i < eng_lat && !rst; i++) @(negedge clk);
            if (!rst) begin
               eng_done_m = 1'b1;
               @(negedge clk);
               eng_done_m   = 1'b0;
               eng_data_out = r;
            end
         end
      end
   end

   // Monitor: checks every launch and every done against the scoreboard queues.
   initial begin
      logic prev_tx;
      exp_done_t   d;
      exp_launch_t l;
      prev_tx = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_tx = 1'b0;
         end else begin
            if (done != 4'b0) begin
               if (done_q.size() == 0) chk("done_unexpected", {28'b0, done}, 0);
               else begin
                  d = done_q.pop_front();
                  chk("done_vec", {28'b0, done}, {28'b0, d.done});
                  chk("rx_data", {24'b0, rx_data}, {24'b0, d.rx});
                  chk("err", {31'b0, err}, {31'b0, d.err});
                  chk("gnt_at_done", {28'b0, gnt}, 0);
               end
            end
            if (eng_tx_dp) begin
               chk("tx_dp_width", {31'b0, prev_tx}, 0);
               if (launch_q.size() == 0) chk("launch_unexpected", {28'b0, gnt}, 0);
               else begin
                  l = launch_q.pop_front();
                  chk("gnt", {28'b0, gnt}, {28'b0, l.gnt});
                  chk("eng_data_in", {24'b0, eng_data_in}, {24'b0, l.data});
               end
            end
            prev_tx = eng_tx_dp;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_gnt"},  {28'b0, gnt}, 0);
      chk({nm, "_done"}, {28'b0, done}, 0);
      chk({nm, "_rx"},   {24'b0, rx_data}, 0);
      chk({nm, "_err"},  {31'b0, err}, 0);
      chk({nm, "_busy"}, {31'b0, busy}, 0);
      chk({nm, "_din"},  {24'b0, eng_data_in}, 0);
      chk({nm, "_txdp"}, {31'b0, eng_tx_dp}, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single request from requester 2.
      req_data = 32'h44_A5_22_11;
      exp_xfer(2, 8'hA5, 8'h3C);
      set_req(2, 8'hA5);
      wait_dones(1, 1'b0, "single_done");
      @(negedge clk);
      chk("single_busy_after", {31'b0, busy}, 0);

      // Stray engine done while idle must do nothing.
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stray_busy", {31'b0, busy}, 0);
         chk("stray_done", {28'b0, done}, 0);
         @(negedge clk);
      end

      // Requester 1 alone, then 1 and 3 together: 3 must go first.
      exp_xfer(1, 8'h5B, 8'h81);
      set_req(1, 8'h5B);
      wait_dones(1, 1'b0, "rr_first_done");
      @(negedge clk);
      exp_xfer(3, 8'h7D, 8'h93);
      exp_xfer(1, 8'h5B, 8'h71);
      set_req(1, 8'h5B);
      set_req(3, 8'h7D);
      wait_dones(2, 1'b0, "rr_pair_done");
      @(negedge clk);

`ifdef SPI_SEQ_TIMEOUT_EN
      // Engine never answers: timeout after 20 WAIT cycles.
      begin
         exp_launch_t l;
         exp_done_t   d;
         int n;
         eng_hang = 1'b1;
         l.gnt = 4'b0010; l.data = 8'h66;
         d.done = 4'b0010; d.rx = 8'h00; d.err = 1'b1;
         launch_q.push_back(l);
         done_q.push_back(d);
         set_req(1, 8'h66);
         wait_tx_dp("to_launch");
         n = 0;
         while (done == 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
         end
         req = '0;
         chk("to_latency", n, 21);
         @(negedge clk);
         chk("to_busy_after", {31'b0, busy}, 0);
         eng_hang = 1'b0;
      end
`endif

      // Reset in the middle of WAIT.
      eng_hang = 1'b1;
      begin
         exp_launch_t l;
         l.gnt = 4'b0100; l.data = 8'h9E;
         launch_q.push_back(l);
      end
      set_req(2, 8'h9E);
      wait_tx_dp("mid_launch");
      repeat (2) @(negedge clk);
      chk("mid_wait_busy", {31'b0, busy}, 1);
      rst = 1'b1;
      #1;
      chk_all_zero("mid_rst");
      req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      eng_hang = 1'b0;
      @(negedge clk);

      // Fairness: all four held, order 0,1,2,3,0 starting from reset.
      req_data = 32'h43_32_21_10;
      exp_xfer(0, 8'h10, 8'hC0);
      exp_xfer(1, 8'h21, 8'hC1);
      exp_xfer(2, 8'h32, 8'hC2);
      exp_xfer(3, 8'h43, 8'hC3);
      exp_xfer(0, 8'h10, 8'hC4);
      req = 4'hF;
      wait_dones(5, 1'b1, "fair_dones");
      repeat (4) @(negedge clk);
      chk("fair_idle", {31'b0, busy}, 0);

      chk("done_q_empty", done_q.size(), 0);
      chk("launch_q_empty", launch_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
